// File: rtl/cpu_pkg.sv
// Shared CPU types and constants for the fetch front end.
// Struct gains a fault bit when IFU_BOUNDS_CHK_EN is defined.
package cpu_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [ADDR_W-1:0]  RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0000;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
        logic [ADDR_W-1:0]  pc_plus4;
        logic               valid;
`ifdef IFU_BOUNDS_CHK_EN
        logic               fault;
`endif
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with hold and synchronous flush.
// Flush wins over hold; fault bit exists with IFU_BOUNDS_CHK_EN.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter logic [INSTR_W-1:0] NOP_WORD = cpu_pkg::NOP_INSTR
) (
    input  logic   clk_i,
    input  logic   flush_i,
    input  logic   hold_i,
    input  if_id_t d_i,
    output if_id_t q_o
);

    if_id_t q_q;

    // Flush loads a bubble, hold freezes, otherwise capture the fetch.
    always_ff @(posedge clk_i) begin
        if (flush_i) begin
            q_q.instr    <= NOP_WORD;
            q_q.pc       <= '0;
            q_q.pc_plus4 <= '0;
            q_q.valid    <= 1'b0;
`ifdef IFU_BOUNDS_CHK_EN
            q_q.fault    <= 1'b0;
`endif
        end else if (!hold_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// PC, fetch FSM and memory address generation for the front end.
// Define IFU_BOUNDS_CHK_EN to flag misaligned/out-of-range fetches.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = cpu_pkg::RESET_PC_DEFAULT,
    parameter int          IMEM_DEPTH = 1024,
    parameter logic [31:0] NOP_INSTR  = cpu_pkg::NOP_INSTR
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        stall,
    input  logic                        redirect,
    input  logic [cpu_pkg::ADDR_W-1:0]  redirect_target,
    output logic [cpu_pkg::ADDR_W-1:0]  imem_addr,
    input  logic [cpu_pkg::INSTR_W-1:0] imem_instruction,
    output logic [cpu_pkg::INSTR_W-1:0] id_instruction,
    output logic [cpu_pkg::ADDR_W-1:0]  id_pc,
    output logic [cpu_pkg::ADDR_W-1:0]  id_pc_plus4,
`ifdef IFU_BOUNDS_CHK_EN
    output logic                        fetch_fault,
`endif
    output logic                        id_valid
);

    import cpu_pkg::*;

`ifdef IFU_BOUNDS_CHK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    localparam logic [31:0] DEPTH_WORDS = 32'(IMEM_DEPTH);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]  pc_plus4;
    logic               fetch_bad;
    logic               flush;
    logic               hold;
    if_id_t             ifid_d;
    if_id_t             ifid_q;

    assign pc_plus4 = fetch_pc_q + 32'd4;

    // Tag of the word now on imem_instruction is faulty.
    assign fetch_bad = BOUNDS_EN &&
                       ((fetch_pc_q[1:0] != 2'b00) ||
                        ({2'b00, fetch_pc_q[31:2]} >= DEPTH_WORDS));

    // State and fetch tag register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    // Next state, memory address and IF/ID control.
    always_comb begin
        state_d         = state_q;
        fetch_pc_d      = fetch_pc_q;
        imem_addr       = fetch_pc_q;
        flush           = 1'b0;
        hold            = 1'b1;
        ifid_d.instr    = imem_instruction;
        ifid_d.pc       = fetch_pc_q;
        ifid_d.pc_plus4 = pc_plus4;
        ifid_d.valid    = 1'b1;
`ifdef IFU_BOUNDS_CHK_EN
        ifid_d.fault    = 1'b0;
`endif
        unique case (state_q)
            BOOT: begin
                imem_addr  = redirect ? redirect_target : RESET_PC;
                fetch_pc_d = imem_addr;
                state_d    = RUN;
                flush      = 1'b1;
            end
            RUN: begin
                if (redirect) begin
                    imem_addr  = redirect_target;
                    fetch_pc_d = redirect_target;
                    flush      = 1'b1;
                end else if (stall) begin
                    imem_addr = fetch_pc_q;
                end else begin
                    imem_addr  = pc_plus4;
                    fetch_pc_d = pc_plus4;
                    hold       = 1'b0;
                    if (fetch_bad) begin
                        ifid_d.instr = NOP_INSTR;
                        ifid_d.valid = 1'b0;
`ifdef IFU_BOUNDS_CHK_EN
                        ifid_d.fault = 1'b1;
`endif
                    end
                end
            end
            default: begin
                state_d = BOOT;
                flush   = 1'b1;
            end
        endcase
        if (RST) begin
            imem_addr = RESET_PC;
        end
    end

    if_id_reg #(
        .NOP_WORD (NOP_INSTR)
    ) u_if_id (
        .clk_i   (CLK),
        .flush_i (RST | flush),
        .hold_i  (hold),
        .d_i     (ifid_d),
        .q_o     (ifid_q)
    );

    assign id_instruction = ifid_q.instr;
    assign id_pc          = ifid_q.pc;
    assign id_pc_plus4    = ifid_q.pc_plus4;
    assign id_valid       = ifid_q.valid;
`ifdef IFU_BOUNDS_CHK_EN
    assign fetch_fault    = ifid_q.fault;
`endif

endmodule
